// File: rtl/huffman_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : huffman_pkg
// Description : Shared sizes, node count and FSM encoding for the Huffman
//               code-table builder.
// Revision    : 1.0 - initial release
// ============================================================================
package huffman_pkg;

  localparam int NSYM    = 10;           // alphabet size, symbols 0..9
  localparam int NCHAR   = 256;          // symbols per block
  localparam int SYM_W   = 4;
  localparam int FREQ_W  = 13;
  localparam int LEN_W   = 4;
  localparam int CODE_W  = 9;
  localparam int ENTRY_W = 13;           // {length, code}
  localparam int NNODE   = 2 * NSYM - 1; // 10 leaves + 9 internal nodes = 19
  localparam int NODE_W  = $clog2(NNODE);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_COUNT = 3'd1;
  localparam logic [2:0] ST_TREE  = 3'd2;
  localparam logic [2:0] ST_CODE  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_COUNT = ST_COUNT,
    S_TREE  = ST_TREE,
    S_CODE  = ST_CODE,
    S_DONE  = ST_DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/huff_min2_select.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : huff_min2_select
// Description : Combinational pick of the two lightest active nodes out of
//               the 19-node tree; ties go to the lower node index.
// Revision    : 1.0 - initial release
// ============================================================================
module huff_min2_select
  import huffman_pkg::*;
(
  input  logic [NNODE*FREQ_W-1:0] i_weights,
  input  logic [NNODE-1:0]        i_active,
  output logic [NODE_W-1:0]       o_idx_a,
  output logic [NODE_W-1:0]       o_idx_b,
  output logic [FREQ_W-1:0]       o_w_a,
  output logic [FREQ_W-1:0]       o_w_b,
  output logic                    o_found
);

  logic w_have_a;
  logic w_have_b;

  // Lightest active node; strict '<' keeps the lowest index on ties.
  always_comb begin
    w_have_a = 1'b0;
    o_idx_a  = '0;
    o_w_a    = '0;
    for (int i = 0; i < NNODE; i++) begin
      if (i_active[i] && (!w_have_a || (i_weights[i*FREQ_W +: FREQ_W] < o_w_a))) begin
        w_have_a = 1'b1;
        o_idx_a  = NODE_W'(i);
        o_w_a    = i_weights[i*FREQ_W +: FREQ_W];
      end
    end
  end

  // Second lightest active node, excluding the first pick.
  always_comb begin
    w_have_b = 1'b0;
    o_idx_b  = '0;
    o_w_b    = '0;
    for (int i = 0; i < NNODE; i++) begin
      if (i_active[i] && (NODE_W'(i) != o_idx_a) &&
          (!w_have_b || (i_weights[i*FREQ_W +: FREQ_W] < o_w_b))) begin
        w_have_b = 1'b1;
        o_idx_b  = NODE_W'(i);
        o_w_b    = i_weights[i*FREQ_W +: FREQ_W];
      end
    end
  end

  assign o_found = w_have_a && w_have_b;

endmodule
`default_nettype wire

// File: rtl/huffman_code_builder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : huffman_code_builder
// Description : Builds a Huffman code table for a 256-symbol block:
//               COUNT (256 cycles) -> TREE (9 cycles) -> CODE (10 cycles)
//               -> DONE. done rises one cycle after DONE is entered.
//               Optional macro HUFF_FREQ_PORT_EN adds the freq_out port.
// Revision    : 1.0 - initial release
// ============================================================================
module huffman_code_builder
  import huffman_pkg::*;
#(
  parameter int NSYM  = 10,
  parameter int NCHAR = 256
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     start,
  input  logic [NCHAR*SYM_W-1:0]   character_in,
  output logic [NSYM*ENTRY_W-1:0]  code_table,
  output logic                     busy,
  output logic                     done
`ifdef HUFF_FREQ_PORT_EN
  ,
  output logic [NSYM*FREQ_W-1:0]   freq_out
`endif
);

  // One counter serves COUNT (0..NCHAR-1), TREE (0..8) and CODE (0..9).
  localparam int c_cnt_w = ($clog2(NCHAR) > 4) ? $clog2(NCHAR) : 4;

  state_t                   r_state;
  logic [c_cnt_w-1:0]       r_cnt;
  logic [NCHAR*SYM_W-1:0]   r_chars;      // latched block, shifted one symbol per COUNT cycle
  logic [FREQ_W-1:0]        r_freq [NSYM];
  logic [FREQ_W-1:0]        r_iw   [NSYM-1];
  logic [NODE_W-1:0]        r_par  [NNODE];
  logic [NNODE-1:0]         r_merged;
  logic [NNODE-1:0]         r_has_par;
  logic [NNODE-1:0]         r_bit;        // branch bit from this node to its parent
  logic [3:0]               r_nmerge;
  logic                     r_done;
  logic [NSYM*ENTRY_W-1:0]  r_table;

  logic [SYM_W-1:0]         w_sym;
  logic [NNODE*FREQ_W-1:0]  w_weights;
  logic [NNODE-1:0]         w_active;
  logic [NODE_W-1:0]        w_idx_a;
  logic [NODE_W-1:0]        w_idx_b;
  logic [FREQ_W-1:0]        w_w_a;
  logic [FREQ_W-1:0]        w_w_b;
  logic                     w_found;
  logic [SYM_W-1:0]         w_leaf;
  logic [NODE_W-1:0]        w_cur;
  logic [LEN_W-1:0]         w_len;
  logic [CODE_W-1:0]        w_code;
  logic                     w_leaf_nz;
  logic [ENTRY_W-1:0]       w_entry;

  assign w_sym = r_chars[SYM_W-1:0];

  // Leaves carry the symbol counts; a node is active while it has weight and no parent.
  for (genvar gi = 0; gi < NSYM; gi++) begin : g_leaf
    assign w_weights[gi*FREQ_W +: FREQ_W] = r_freq[gi];
    assign w_active[gi] = (r_freq[gi] != '0) && !r_merged[gi];
  end

  // Internal nodes have zero weight until created, so they are inactive before then.
  for (genvar gj = 0; gj < NSYM-1; gj++) begin : g_inner
    assign w_weights[(NSYM+gj)*FREQ_W +: FREQ_W] = r_iw[gj];
    assign w_active[NSYM+gj] = (r_iw[gj] != '0) && !r_merged[NSYM+gj];
  end

  huff_min2_select u_min2 (
    .i_weights (w_weights),
    .i_active  (w_active),
    .o_idx_a   (w_idx_a),
    .o_idx_b   (w_idx_b),
    .o_w_a     (w_w_a),
    .o_w_b     (w_w_b),
    .o_found   (w_found)
  );

  // Walk leaf r_cnt up to the root; bits land LSB-first so the root bit ends up MSB.
  always_comb begin
    w_leaf    = r_cnt[SYM_W-1:0];
    w_cur     = NODE_W'(w_leaf);
    w_len     = '0;
    w_code    = '0;
    w_leaf_nz = 1'b0;
    for (int i = 0; i < NSYM; i++) begin
      if (w_leaf == SYM_W'(i)) w_leaf_nz = (r_freq[i] != '0);
    end
    for (int d = 0; d < CODE_W; d++) begin
      if (r_has_par[w_cur]) begin
        w_code[d] = r_bit[w_cur];
        w_len     = w_len + 1'b1;
        w_cur     = r_par[w_cur];
      end
    end
    // A lone nonzero symbol has no parent but still needs a 1-bit code.
    if (w_len != '0)   w_entry = {w_len, w_code};
    else if (w_leaf_nz) w_entry = {LEN_W'(1), CODE_W'(0)};
    else               w_entry = '0;
  end

  // Main sequencer: counting, tree merging, code extraction and handshake.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_chars   <= '0;
      r_merged  <= '0;
      r_has_par <= '0;
      r_bit     <= '0;
      r_nmerge  <= '0;
      r_done    <= 1'b0;
      r_table   <= '0;
      for (int i = 0; i < NSYM; i++)   r_freq[i] <= '0;
      for (int j = 0; j < NSYM-1; j++) r_iw[j]   <= '0;
      for (int n = 0; n < NNODE; n++)  r_par[n]  <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state   <= S_COUNT;
            r_cnt     <= '0;
            r_chars   <= character_in;
            r_merged  <= '0;
            r_has_par <= '0;
            r_bit     <= '0;
            r_nmerge  <= '0;
            r_done    <= 1'b0;
            r_table   <= '0;
            for (int i = 0; i < NSYM; i++)   r_freq[i] <= '0;
            for (int j = 0; j < NSYM-1; j++) r_iw[j]   <= '0;
            for (int n = 0; n < NNODE; n++)  r_par[n]  <= '0;
          end else if (r_state == S_DONE) begin
            r_done <= 1'b1;
          end
        end
        S_COUNT: begin
          for (int i = 0; i < NSYM; i++) begin
            if (w_sym == SYM_W'(i)) r_freq[i] <= r_freq[i] + 1'b1;
          end
          r_chars <= r_chars >> SYM_W;
          if (r_cnt == c_cnt_w'(NCHAR-1)) begin
            r_cnt   <= '0;
            r_state <= S_TREE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_TREE: begin
          if (w_found) begin
            r_iw[r_nmerge]     <= w_w_a + w_w_b;
            r_merged[w_idx_a]  <= 1'b1;
            r_merged[w_idx_b]  <= 1'b1;
            r_has_par[w_idx_a] <= 1'b1;
            r_has_par[w_idx_b] <= 1'b1;
            r_bit[w_idx_a]     <= 1'b0;
            r_bit[w_idx_b]     <= 1'b1;
            r_par[w_idx_a]     <= NODE_W'(NSYM) + NODE_W'(r_nmerge);
            r_par[w_idx_b]     <= NODE_W'(NSYM) + NODE_W'(r_nmerge);
            r_nmerge           <= r_nmerge + 1'b1;
          end
          if (r_cnt == c_cnt_w'(NSYM-2)) begin
            r_cnt   <= '0;
            r_state <= S_CODE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_CODE: begin
          r_table[r_cnt*ENTRY_W +: ENTRY_W] <= w_entry;
          if (r_cnt == c_cnt_w'(NSYM-1)) begin
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == S_COUNT) || (r_state == S_TREE) || (r_state == S_CODE);
  assign done       = r_done;
  assign code_table = r_table;

`ifdef HUFF_FREQ_PORT_EN
  for (genvar gf = 0; gf < NSYM; gf++) begin : g_freq
    assign freq_out[gf*FREQ_W +: FREQ_W] = r_freq[gf];
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_huffman_code_builder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_huffman_code_builder
// Description : Scoreboard bench: stimulus pushes the expected table per
//               block, a negedge monitor pops and compares on done rising.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_huffman_code_builder;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          start = 1'b0;
  logic [1023:0] character_in = '0;
  logic [129:0]  code_table;
  logic          busy;
  logic          done;
`ifdef HUFF_FREQ_PORT_EN
  logic [129:0]  freq_out;
`endif

  huffman_code_builder dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .start        (start),
    .character_in (character_in),
    .code_table   (code_table),
    .busy         (busy),
    .done         (done)
`ifdef HUFF_FREQ_PORT_EN
    ,
    .freq_out     (freq_out)
`endif
  );

  always #5 CLK = ~CLK;

  int edge_cnt = 0;
  always @(posedge CLK) edge_cnt++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string        name;
    logic [129:0] tbl;
    int           start_edge;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  logic prev_done = 1'b0;

  function automatic logic [129:0] put(input logic [129:0] t, input int sym,
                                       input int len, input int code);
    logic [129:0] r;
    r = t;
    r[sym*13 +: 13] = {len[3:0], code[8:0]};
    return r;
  endfunction

  task automatic check(input string name, input logic [129:0] act, input logic [129:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: on each rising done, pop the oldest expectation and compare.
  always @(negedge CLK) begin
    if (done && !prev_done) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 expected no pending block");
      end else begin
        m_e = sb.pop_front();
        for (int k = 0; k < 10; k++)
          check($sformatf("%s entry%0d", m_e.name, k),
                {117'd0, code_table[k*13 +: 13]}, {117'd0, m_e.tbl[k*13 +: 13]});
        check({m_e.name, " latency"}, 130'(edge_cnt - m_e.start_edge), 130'd276);
        check({m_e.name, " busy_at_done"}, {129'd0, busy}, 130'd0);
      end
    end
    prev_done = done;
  end

  task automatic run_block(input string name, input logic [1023:0] chars,
                           input logic [129:0] tbl, input bit noisy);
    exp_t e;
    bit   seen;
    @(negedge CLK);
    e.name       = name;
    e.tbl        = tbl;
    e.start_edge = edge_cnt + 1;
    sb.push_back(e);
    character_in = chars;
    start        = 1'b1;
    @(negedge CLK);
    start        = 1'b0;
    character_in = '1;  // scrambled input: results must come from the latched block
    seen = 1'b0;
    for (int i = 1; i <= 400 && !seen; i++) begin
      start = noisy && (i == 50 || i == 258 || i == 268);
      @(negedge CLK);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no done in 400 cycles expected done", name);
      void'(sb.pop_back());
    end else begin
      repeat (3) @(negedge CLK);
      check({name, " done_hold"}, {129'd0, done}, 130'd1);
      check({name, " table_hold"}, code_table, tbl);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] v3, v01, vdist, v15, v4, v712;
    logic [129:0]  t3, t01, tdist, t4, t712;

    for (int k = 0; k < 256; k++) begin
      v3[k*4 +: 4]    = 4'd3;
      v01[k*4 +: 4]   = (k < 128) ? 4'd0 : 4'd1;
      vdist[k*4 +: 4] = (k < 128) ? 4'd0 : (k < 192) ? 4'd1 : (k < 224) ? 4'd2 :
                        (k < 240) ? 4'd3 : (k < 248) ? 4'd4 : 4'd5;
      v15[k*4 +: 4]   = 4'd15;
      v4[k*4 +: 4]    = 4'(k % 4);
      v712[k*4 +: 4]  = (k % 2 == 0) ? 4'd7 : 4'd12;
    end
    t3    = put('0, 3, 1, 0);
    t01   = put(put('0, 0, 1, 0), 1, 1, 1);
    tdist = put(put(put(put(put(put('0, 0, 1, 0), 1, 2, 2), 2, 3, 6), 3, 4, 14), 4, 5, 30), 5, 5, 31);
    t4    = put(put(put(put('0, 0, 2, 0), 1, 2, 1), 2, 2, 2), 3, 2, 3);
    t712  = put('0, 7, 1, 0);

    repeat (3) @(negedge CLK);
    check("reset busy", {129'd0, busy}, 130'd0);
    check("reset done", {129'd0, done}, 130'd0);
    check("reset table", code_table, 130'd0);
    nRST = 1'b1;

    run_block("all3", v3, t3, 1'b0);
    run_block("half01", v01, t01, 1'b0);
    run_block("skewed", vdist, tdist, 1'b0);
    run_block("all15", v15, '0, 1'b0);
    run_block("skewed_noisy", vdist, tdist, 1'b1);

    // Asynchronous reset in the middle of COUNT.
    @(negedge CLK);
    character_in = vdist;
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (100) @(negedge CLK);
    check("midcount busy", {129'd0, busy}, 130'd1);
    #2 nRST = 1'b0;
    #1;
    check("midreset busy", {129'd0, busy}, 130'd0);
    check("midreset done", {129'd0, done}, 130'd0);
    check("midreset table", code_table, 130'd0);
    @(negedge CLK);
    nRST = 1'b1;

    run_block("sym7_with_invalid", v712, t712, 1'b0);
    run_block("four_equal", v4, t4, 1'b0);

    // Asynchronous reset while a finished table is being held.
    @(negedge CLK);
    #2 nRST = 1'b0;
    #1;
    check("donereset done", {129'd0, done}, 130'd0);
    check("donereset table", code_table, 130'd0);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    check("scoreboard drained", 130'(sb.size()), 130'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
